// File: rtl/baluga_pkg.sv
// Shared definitions for the MEX/WB pipeline boundary of the 8-bit CPU:
// default widths, the memory-handshake state enum and the WB-stage bus.
package baluga_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 3;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mex_state_t;

    // Register contents presented to the WB stage. Widths follow the
    // package defaults, so the top must be built with matching widths.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] reg2;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
    } mex_wb_bus_t;

endpackage

// File: rtl/mex_mem_ctrl.sv
// Data-memory handshake controller for the MEX/WB register.
// Owns the IDLE/MEM_WAIT FSM, the sticky killed flag and, when built with
// MEX_MEM_TIMEOUT_EN, the ack timeout counter and the mem_err pulse.
//
// Handshake: mem_req rises on the edge that accepts a load/store and stays
// high, with mem_we/address/data frozen, until the cycle in which mem_ack
// (a one-cycle pulse) is seen; the following edge drops mem_req. An ack
// outside MEM_WAIT carries no meaning and is ignored.
module mex_mem_ctrl
    import baluga_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       mem_op,
    input  logic       store,
    input  logic       flush,
    input  logic       mem_ack,
    output mex_state_t state,
    output logic       stall,
    output logic       mem_req,
    output logic       mem_we,
    output logic       accept,
    output logic       retire,
    output logic       retire_kill
`ifdef MEX_MEM_TIMEOUT_EN
    ,
    output logic       timeout,
    output logic       mem_err
`endif
);

    mex_state_t state_q;
    mex_state_t state_d;
    logic       killed_q;
    logic       we_q;
    logic       timeout_hit;

`ifdef MEX_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    // Next-state and handshake events.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && mem_op && !flush) begin
                    accept  = 1'b1;
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
`ifdef MEX_MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, write-select and killed flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            killed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q <= store;
            end else if (state_d == IDLE) begin
                we_q <= 1'b0;
            end
            // A flush in flight cannot abort the access; remember it so the
            // instruction retires as a bubble.
            if (state_q == MEM_WAIT && state_d == IDLE) begin
                killed_q <= 1'b0;
            end else if (state_q == MEM_WAIT && flush) begin
                killed_q <= 1'b1;
            end
        end
    end

`ifdef MEX_MEM_TIMEOUT_EN
    // Cycles spent waiting for ack, restarted on every new access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
            end else if (state_q == MEM_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            err_q <= timeout_hit;
        end
    end

    assign timeout = timeout_hit;
    assign mem_err = err_q;
`endif

    assign state       = state_q;
    assign stall       = (state_q == MEM_WAIT);
    assign mem_req     = (state_q == MEM_WAIT);
    assign mem_we      = we_q;
    // A flush arriving in the ack cycle itself also kills the instruction.
    assign retire_kill = killed_q | flush;

endmodule

// File: rtl/mex_wb_pipe.sv
// MEX -> WB pipeline register of the 8-bit CPU.
// Captures the ALU result, operand 2, destination and write enable, and for
// loads/stores runs the data-memory handshake (via mex_mem_ctrl) while
// stalling upstream. wb_data selects load data or the ALU result.
// Optional build macro: MEX_MEM_TIMEOUT_EN adds an ack timeout and mem_err.
module mex_wb_pipe #(
    parameter int DATA_W      = 8,
    parameter int REG_AW      = 3,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              flush,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mex_wb_valid,
    output logic [DATA_W-1:0] mex_wb_alu_res,
    output logic [DATA_W-1:0] mex_wb_reg2,
    output logic [REG_AW-1:0] mex_wb_dst,
    output logic              mex_wb_reg_write,
    output logic [DATA_W-1:0] wb_data
`ifdef MEX_MEM_TIMEOUT_EN
    ,
    output logic              mem_err
`endif
);

    import baluga_pkg::*;

    mex_state_t  state;
    mex_wb_bus_t bus_q;
    logic        pend_rw_q;
    logic [DATA_W-1:0] wb_q;
    logic        mem_op;
    logic        accept;
    logic        retire;
    logic        retire_kill;

    // Write wins when both read and write are flagged: treated as a store.
    assign mem_op = in_mem_read | in_mem_write;

    mex_mem_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .mem_op      (mem_op),
        .store       (in_mem_write),
        .flush       (flush),
        .mem_ack     (mem_ack),
        .state       (state),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .accept      (accept),
        .retire      (retire),
        .retire_kill (retire_kill)
`ifdef MEX_MEM_TIMEOUT_EN
        ,
        .timeout     (),
        .mem_err     (mem_err)
`endif
    );

    // Datapath registers: capture in IDLE, retire memory ops on ack. A
    // timed-out access simply falls through the non-ack path as a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q     <= '0;
            pend_rw_q <= 1'b0;
            wb_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !flush) begin
                        bus_q.alu_res <= in_alu_res;
                        bus_q.reg2    <= in_reg2;
                        bus_q.dst     <= in_dst;
                        pend_rw_q     <= in_reg_write;
                        if (mem_op) begin
                            bus_q.valid     <= 1'b0;
                            bus_q.reg_write <= 1'b0;
                        end else begin
                            bus_q.valid     <= 1'b1;
                            bus_q.reg_write <= in_reg_write;
                            wb_q            <= in_alu_res;
                        end
                    end else begin
                        bus_q.valid     <= 1'b0;
                        bus_q.reg_write <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (retire) begin
                        bus_q.valid     <= ~retire_kill;
                        bus_q.reg_write <= pend_rw_q & ~retire_kill;
                        wb_q            <= mem_we ? bus_q.alu_res : mem_rdata;
                    end else begin
                        bus_q.valid     <= 1'b0;
                        bus_q.reg_write <= 1'b0;
                    end
                end
                default: begin
                    bus_q.valid     <= 1'b0;
                    bus_q.reg_write <= 1'b0;
                end
            endcase
        end
    end

    // accept is implied by the state change; the datapath keys off state.
    logic unused_accept;
    assign unused_accept = accept;

    assign mex_wb_valid     = bus_q.valid;
    assign mex_wb_alu_res   = bus_q.alu_res;
    assign mex_wb_reg2      = bus_q.reg2;
    assign mex_wb_dst       = bus_q.dst;
    assign mex_wb_reg_write = bus_q.reg_write;
    assign wb_data          = wb_q;
    // Address and store data are the captured fields, frozen in MEM_WAIT.
    assign mem_addr         = bus_q.alu_res;
    assign mem_wdata        = bus_q.reg2;

endmodule

// File: tb/tb_mex_wb_pipe.sv
// Bench for mex_wb_pipe: directed steps followed by random traffic, checked
// every cycle against a transaction-level model of the pipeline register.
module tb_mex_wb_pipe;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int TO = 15;
`ifdef MEX_MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_alu_res = '0;
    logic [DW-1:0] in_reg2 = '0;
    logic [AW-1:0] in_dst = '0;
    logic          in_reg_write = 1'b0;
    logic          in_mem_read = 1'b0;
    logic          in_mem_write = 1'b0;
    logic          flush = 1'b0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall, mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mex_wb_valid, mex_wb_reg_write;
    logic [DW-1:0] mex_wb_alu_res, mex_wb_reg2, wb_data;
    logic [AW-1:0] mex_wb_dst;
    logic          mem_err_obs;

    mex_wb_pipe #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_alu_res(in_alu_res),
        .in_reg2(in_reg2), .in_dst(in_dst), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .flush(flush),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mex_wb_valid(mex_wb_valid), .mex_wb_alu_res(mex_wb_alu_res),
        .mex_wb_reg2(mex_wb_reg2), .mex_wb_dst(mex_wb_dst),
        .mex_wb_reg_write(mex_wb_reg_write), .wb_data(wb_data)
`ifdef MEX_MEM_TIMEOUT_EN
        , .mem_err(mem_err_obs)
`endif
    );
`ifndef MEX_MEM_TIMEOUT_EN
    assign mem_err_obs = 1'b0;
`endif

    // ---------------- reference model ----------------
    typedef struct {
        bit we;
        bit rw;
        bit killed;
        int age;
    } op_t;
    op_t outq[$];          // outstanding memory access (0 or 1 entries)

    logic [DW-1:0] m_alu, m_reg2, m_wb;
    logic [AW-1:0] m_dst;
    logic          m_valid, m_rw, m_err;
    logic [DW-1:0] exp_q[$];   // expected wb_data of each retirement

    int n_checks = 0;
    int n_fail   = 0;

    task automatic model_reset();
        outq.delete();
        exp_q.delete();
        m_alu = '0; m_reg2 = '0; m_wb = '0; m_dst = '0;
        m_valid = 1'b0; m_rw = 1'b0; m_err = 1'b0;
    endtask

    // Effect of the coming clock edge, from the inputs currently applied.
    task automatic model_edge();
        op_t op;
        bit  kill;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_err = 1'b0;
        if (outq.size() == 0) begin
            m_valid = 1'b0;
            m_rw    = 1'b0;
            if (in_valid && !flush) begin
                m_alu = in_alu_res; m_reg2 = in_reg2; m_dst = in_dst;
                if (in_mem_read || in_mem_write) begin
                    op.we = in_mem_write; op.rw = in_reg_write;
                    op.killed = 1'b0; op.age = 0;
                    outq.push_back(op);
                end else begin
                    m_valid = 1'b1; m_rw = in_reg_write; m_wb = in_alu_res;
                end
            end
        end else begin
            op   = outq[0];
            kill = op.killed || flush;
            m_valid = 1'b0;
            m_rw    = 1'b0;
            if (mem_ack) begin
                void'(outq.pop_front());
                m_valid = !kill;
                m_rw    = op.rw && !kill;
                m_wb    = op.we ? m_alu : mem_rdata;
            end else if (TO_EN && (op.age + 1 >= TO)) begin
                void'(outq.pop_front());
                m_err = 1'b1;
            end else begin
                outq[0].age    = op.age + 1;
                outq[0].killed = kill;
            end
        end
        if (m_valid) exp_q.push_back(m_wb);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit busy;
        busy = (outq.size() != 0);
        check("stall",     32'(stall),   32'(busy));
        check("mem_req",   32'(mem_req), 32'(busy));
        check("mem_we",    32'(mem_we),  32'(busy ? outq[0].we : 1'b0));
        check("mem_addr",  32'(mem_addr),  32'(m_alu));
        check("mem_wdata", 32'(mem_wdata), 32'(m_reg2));
        check("valid",     32'(mex_wb_valid), 32'(m_valid));
        check("alu_res",   32'(mex_wb_alu_res), 32'(m_alu));
        check("reg2",      32'(mex_wb_reg2), 32'(m_reg2));
        check("dst",       32'(mex_wb_dst), 32'(m_dst));
        check("reg_write", 32'(mex_wb_reg_write), 32'(m_rw));
        check("wb_data",   32'(wb_data), 32'(m_wb));
        if (TO_EN) check("mem_err", 32'(mem_err_obs), 32'(m_err));
        if (mex_wb_valid === 1'b1) begin
            check("retire_pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) check("retire_data", 32'(wb_data), 32'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_reg_write = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic drive_op(input logic [DW-1:0] alu, input logic [DW-1:0] r2,
                            input logic [AW-1:0] dst, input logic rw,
                            input logic rd, input logic wr);
        in_valid = 1'b1; in_alu_res = alu; in_reg2 = r2; in_dst = dst;
        in_reg_write = rw; in_mem_read = rd; in_mem_write = wr;
        flush = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic drive_random();
        rst_n        = ($urandom_range(0, 99) != 0);
        in_valid     = ($urandom_range(0, 3) != 0);
        in_alu_res   = DW'($urandom);
        in_reg2      = DW'($urandom);
        in_dst       = AW'($urandom);
        in_reg_write = 1'($urandom);
        in_mem_read  = ($urandom_range(0, 3) == 0);
        in_mem_write = ($urandom_range(0, 3) == 0);
        flush        = ($urandom_range(0, 9) == 0);
        mem_ack      = ($urandom_range(0, 2) == 0);
        mem_rdata    = DW'($urandom);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        model_reset();

        // Reset with random inputs for two cycles.
        for (int i = 0; i < 2; i++) begin
            drive_random();
            rst_n = 1'b0;
            step();
        end
        check("rst_valid", 32'(mex_wb_valid), 32'(0));
        check("rst_wb", 32'(wb_data), 32'(0));
        check("rst_alu", 32'(mex_wb_alu_res), 32'(0));
        check("rst_stall", 32'(stall), 32'(0));
        rst_n = 1'b1;
        drive_idle();
        step();

        // ALU op: one-cycle latency.
        drive_op(8'h3C, 8'h11, 3'd5, 1'b1, 1'b0, 1'b0);
        step();
        check("alu_valid", 32'(mex_wb_valid), 32'(1));
        check("alu_res_v", 32'(mex_wb_alu_res), 32'(8'h3C));
        check("alu_reg2_v", 32'(mex_wb_reg2), 32'(8'h11));
        check("alu_wb", 32'(wb_data), 32'(8'h3C));
        check("alu_rw", 32'(mex_wb_reg_write), 32'(1));
        check("alu_stall", 32'(stall), 32'(0));

        // Bubble with a stray ack in IDLE.
        drive_idle();
        mem_ack = 1'b1;
        in_alu_res = 8'hFF;
        step();
        check("bub_valid", 32'(mex_wb_valid), 32'(0));
        check("bub_req", 32'(mem_req), 32'(0));
        check("bub_alu_hold", 32'(mex_wb_alu_res), 32'(8'h3C));
        drive_idle();
        step();

        // Load, ack three cycles after the request.
        drive_op(8'h80, 8'h00, 3'd2, 1'b1, 1'b1, 1'b0);
        step();
        drive_idle();
        in_alu_res = 8'h55;
        for (int i = 0; i < 3; i++) begin
            check("ld_stall", 32'(stall), 32'(1));
            check("ld_addr", 32'(mem_addr), 32'(8'h80));
            check("ld_we", 32'(mem_we), 32'(0));
            if (i < 2) step();
        end
        step();
        mem_ack = 1'b1;
        mem_rdata = 8'hA5;
        check("ld_stall_ack", 32'(stall), 32'(1));
        step();
        mem_ack = 1'b0;
        check("ld_valid", 32'(mex_wb_valid), 32'(1));
        check("ld_wb", 32'(wb_data), 32'(8'hA5));
        check("ld_stall_done", 32'(stall), 32'(0));

        // Store flushed one cycle into MEM_WAIT.
        drive_op(8'h40, 8'h7E, 3'd3, 1'b1, 1'b0, 1'b1);
        step();
        drive_idle();
        flush = 1'b1;
        check("st_wdata0", 32'(mem_wdata), 32'(8'h7E));
        check("st_we", 32'(mem_we), 32'(1));
        step();
        flush = 1'b0;
        check("st_wdata1", 32'(mem_wdata), 32'(8'h7E));
        step();
        mem_ack = 1'b1;
        check("st_wdata2", 32'(mem_wdata), 32'(8'h7E));
        step();
        mem_ack = 1'b0;
        check("st_valid", 32'(mex_wb_valid), 32'(0));
        check("st_rw", 32'(mex_wb_reg_write), 32'(0));
        check("st_stall", 32'(stall), 32'(0));

`ifdef MEX_MEM_TIMEOUT_EN
        // Load that never receives an ack.
        drive_op(8'h22, 8'h00, 3'd1, 1'b1, 1'b1, 1'b0);
        step();
        drive_idle();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("to_wait_err", 32'(mem_err_obs), 32'(0));
        end
        step();
        check("to_err", 32'(mem_err_obs), 32'(1));
        check("to_req", 32'(mem_req), 32'(0));
        check("to_stall", 32'(stall), 32'(0));
        check("to_valid", 32'(mex_wb_valid), 32'(0));
        step();
        check("to_err_pulse", 32'(mem_err_obs), 32'(0));
`endif

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mex_wb_pipe.md
Name: mex_wb_pipe

Overview:
- Pipeline register between the MEX (memory/execute) stage and the WB stage of the 8-bit pipelined CPU.
- Captures the ALU result, operand register 2, the destination register and write-back control each cycle.
- For loads and stores it runs a req/ack handshake with data memory and stalls upstream until the access completes.
- Its outputs mex_wb_alu_res and mex_wb_reg2 feed the operand-2 forwarding mux and the write-back path.

Parameters:
- DATA_W, 8, datapath width.
- REG_AW, 3, register-file address width.
- TIMEOUT_CYC, 15, max cycles waiting for mem_ack (used only when the optional feature is compiled in).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  MEX holds a live instruction.
- in_alu_res  in  DATA_W  ALU result; also the memory address.
- in_reg2  in  DATA_W  register 2 value; also the store data.
- in_dst  in  REG_AW  destination register.
- in_reg_write  in  1  instruction writes the register file.
- in_mem_read  in  1  load.
- in_mem_write  in  1  store.
- flush  in  1  kill the instruction being captured or in flight.
- stall  out  1  upstream must hold its ID/MEX register.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DATA_W  memory address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory done; one-cycle pulse.
- mem_rdata  in  DATA_W  load data, valid when mem_ack=1.
- mex_wb_valid  out  1  WB-stage instruction valid.
- mex_wb_alu_res  out  DATA_W  registered ALU result.
- mex_wb_reg2  out  DATA_W  registered register 2.
- mex_wb_dst  out  REG_AW  registered destination.
- mex_wb_reg_write  out  1  registered write enable, gated by valid.
- wb_data  out  DATA_W  write-back value: load data or ALU result.

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low.
- Reset (rst_n=0 at an edge): state=IDLE; all outputs 0, including data fields.
- States: IDLE, MEM_WAIT.
- stall = (state==MEM_WAIT). It is combinational from the state register and is asserted on the ack cycle too.
- IDLE, in_valid=1 and no memory op:
  - Next edge: capture alu_res, reg2, dst; reg_write=in_reg_write; valid=1; wb_data=in_alu_res.
  - Latency is 1 cycle.
- IDLE, in_valid=0 or flush=1: next edge valid=0 and reg_write=0; data fields hold their values.
- IDLE, in_valid=1, (mem_read | mem_write), flush=0:
  - Next edge: state=MEM_WAIT; mem_req=1; mem_we=in_mem_write; mem_addr=in_alu_res; mem_wdata=in_reg2.
  - Data fields are captured; valid=0 and reg_write=0 (WB sees a bubble).
- If in_mem_read and in_mem_write are both 1, the write wins and the instruction is treated as a store.
- MEM_WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack; upstream inputs are ignored.
  - On mem_ack: next edge state=IDLE; mem_req=0; valid=1 unless killed; reg_write=captured reg_write & ~killed.
  - wb_data = mem_rdata for a load, captured alu_res for a store.
- Flush during MEM_WAIT: sets a sticky killed flag. The access still completes (stores are never aborted mid-handshake), then retires with valid=0. killed clears on return to IDLE.
- mem_ack while in IDLE is ignored.
- Back-to-back memory ops: the next op is accepted on the first IDLE cycle after an ack, so there is at least 1 cycle between requests.
- Reset while in MEM_WAIT: next edge IDLE with mem_req=0; the in-flight access is abandoned.

Optional Feature:
- Macro: MEX_MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter of width clog2(TIMEOUT_CYC+1) runs in MEM_WAIT and is cleared on entry to MEM_WAIT.
  - If no mem_ack arrives within TIMEOUT_CYC cycles: return to IDLE, mem_req=0, retire with valid=0.
  - Extra output port mem_err (1 bit) pulses for one cycle; it is 0 after reset.
- Without the macro: MEM_WAIT waits indefinitely, and neither the counter nor mem_err exists.

Decomposition:
- Shared package baluga_pkg holds:
  - DATA_W and REG_AW defaults;
  - the state enum mex_state_t {IDLE, MEM_WAIT};
  - the mex_wb_bus_t struct (valid, alu_res, reg2, dst, reg_write).
- One sub-module, mex_mem_ctrl, holds the handshake FSM, the killed flag and the timeout counter. The top level holds the datapath registers and the wb_data mux.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with random inputs -> every output is 0; stall=0.
- ALU op: in_valid=1, alu_res=0x3C, reg2=0x11, dst=5, reg_write=1 -> next cycle mex_wb_valid=1, alu_res=0x3C, reg2=0x11, wb_data=0x3C, reg_write=1, stall=0.
- Load: alu_res=0x80, mem_read=1; mem_ack given 3 cycles after mem_req with rdata=0xA5 -> mem_addr=0x80 and mem_we=0 held throughout; stall=1 for 4 cycles; then valid=1, wb_data=0xA5.
- Store with flush: mem_write=1, reg2=0x7E; flush pulses 1 cycle into MEM_WAIT; ack arrives 2 cycles later -> mem_wdata=0x7E held until ack; retires with valid=0, reg_write=0.
- Bubble and stray ack: in_valid=0 with mem_ack=1 while in IDLE -> valid=0, mem_req stays 0, data fields hold their previous values.
- Timeout (only with MEX_MEM_TIMEOUT_EN): load with no ack -> after 15 cycles mem_err pulses once, mem_req=0, stall=0, valid=0.
